// File: rtl/para_to_serial_hs_pkg.sv
// Shared definitions for the parallel-to-serial link converter.
package ser_pkg;

  // Legacy-compatible state codes, also exposed as a typed enum.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } ser_state_t;

  // Width of the bit counter for a word of data_w bits.
  function automatic int ser_cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/para_to_serial_hs_if.sv
// Parallel word handshake between the encoder datapath and the serializer.
interface para_to_serial_hs_if #(
  parameter int DATA_W = 10
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // Word source (encoder side).
  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  // Word sink (serializer side).
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/para_to_serial_hs.sv
// Parallel-to-serial converter with a one-word holding buffer so that
// consecutive words stream with no gap bit. MSB- or LSB-first, bit-rate
// strobe, framing, idle level and underrun reporting on the link side.
module para_to_serial_hs
  import ser_pkg::*;
#(
  parameter int   DATA_W    = 10,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  para_to_serial_hs_if.slave   up,
  output logic                 serial_out,
  output logic                 serial_valid,
  output logic                 frame_start,
  output logic                 underrun
);

  localparam int               CNT_W = ser_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_shifted;
  logic [CNT_W-1:0]  cnt;
  ser_state_t        state;
  logic              underrun_r;

  logic              accept;
  logic              last_bit;
  logic              load_sr;

  // Accept needs an empty buffer, unload needs a full one, so they never coincide.
  assign up.in_ready = !hold_full && !rst;
  assign accept      = up.in_valid && !hold_full && !rst;
  assign last_bit    = (cnt == LAST);
  assign load_sr     = bit_en && hold_full && ((state == IDLE) || last_bit);

  // Next shift-register contents; the vacated position is filled with 0.
  always_comb begin
    sr_shifted = '0;
    if (MSB_FIRST) begin
      sr_shifted = {sr[DATA_W-2:0], 1'b0};
    end else begin
      sr_shifted = {1'b0, sr[DATA_W-1:1]};
    end
  end

  // Holding buffer: filled on accept, emptied when the shifter takes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= up.in_data;
      hold_full <= 1'b1;
    end else if (load_sr) begin
      hold_full <= 1'b0;
    end
  end

  // Shifter and state: advance only on bit strobes, reload gaplessly on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else if (bit_en) begin
      if (load_sr) begin
        sr    <= hold;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (!last_bit) begin
          cnt <= cnt + CNT_W'(1);
          sr  <= sr_shifted;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  // Underrun: a word finished and nothing was waiting to follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= bit_en && (state == SHIFT) && last_bit && !hold_full;
    end
  end

  // Link-side outputs, driven only from registers and forced quiet under reset.
  always_comb begin
    serial_out   = IDLE_BIT;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    underrun     = 1'b0;
    if (!rst) begin
      underrun = underrun_r;
      if (state == SHIFT) begin
        serial_out   = MSB_FIRST ? sr[DATA_W-1] : sr[0];
        serial_valid = 1'b1;
        frame_start  = (cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_para_to_serial_hs.sv
// Self-checking bench: two converters (MSB- and LSB-first) share one stimulus
// stream and are compared every cycle against a word/bit-index model.
module tb_para_to_serial_hs;

  localparam int   W        = 10;
  localparam logic IDLE_BIT = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_en = 1'b1;
  int   mode = 0;

  always #5 clk = ~clk;

  para_to_serial_hs_if #(.DATA_W(W)) bus_m ();
  para_to_serial_hs_if #(.DATA_W(W)) bus_l ();

  logic so_m, sv_m, fs_m, ur_m;
  logic so_l, sv_l, fs_l, ur_l;

  para_to_serial_hs #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_BIT)) dut_msb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .up(bus_m),
    .serial_out(so_m), .serial_valid(sv_m), .frame_start(fs_m), .underrun(ur_m)
  );

  para_to_serial_hs #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_BIT)) dut_lsb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .up(bus_l),
    .serial_out(so_l), .serial_valid(sv_l), .frame_start(fs_l), .underrun(ur_l)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The word being sent, which bit index is on the line, and at most one waiting word.
  bit           m_active, m_hold_full, m_under;
  logic [W-1:0] m_cur, m_hold;
  int           m_bi;

  initial begin
    m_active = 0; m_hold_full = 0; m_under = 0; m_cur = '0; m_hold = '0; m_bi = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 0; m_hold_full = 0; m_under = 0; m_bi = 0;
      end else begin
        bit acc;
        acc = bus_m.in_valid && !m_hold_full;
        m_under = 0;
        if (bit_en) begin
          if (m_active) begin
            if (m_bi < W - 1) m_bi++;
            else if (m_hold_full) begin
              m_cur = m_hold; m_hold_full = 0; m_bi = 0;
            end else begin
              m_active = 0; m_under = 1;
            end
          end else if (m_hold_full) begin
            m_cur = m_hold; m_hold_full = 0; m_bi = 0; m_active = 1;
          end
        end
        if (acc) begin
          m_hold = bus_m.in_data; m_hold_full = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic cap_m[$];
  logic cap_l[$];
  int   under_cnt = 0, frame_cnt = 0, valid_cycles = 0, run = 0, max_run = 0;

  initial begin
    forever begin
      logic e_rdy, e_sv, e_fs, e_ur, e_so_m, e_so_l;
      @(negedge clk);
      e_rdy  = !m_hold_full && !rst;
      e_sv   = m_active && !rst;
      e_fs   = e_sv && (m_bi == 0);
      e_ur   = m_under && !rst;
      e_so_m = e_sv ? m_cur[W-1-m_bi] : IDLE_BIT;
      e_so_l = e_sv ? m_cur[m_bi]     : IDLE_BIT;
      check("in_ready_msb",     bus_m.in_ready, e_rdy);
      check("in_ready_lsb",     bus_l.in_ready, e_rdy);
      check("serial_valid_msb", sv_m, e_sv);
      check("serial_valid_lsb", sv_l, e_sv);
      check("frame_start_msb",  fs_m, e_fs);
      check("frame_start_lsb",  fs_l, e_fs);
      check("underrun_msb",     ur_m, e_ur);
      check("underrun_lsb",     ur_l, e_ur);
      check("serial_out_msb",   so_m, e_so_m);
      check("serial_out_lsb",   so_l, e_so_l);
      if (sv_m) begin cap_m.push_back(so_m); valid_cycles++; run++; end
      else run = 0;
      if (sv_l) cap_l.push_back(so_l);
      if (run > max_run) max_run = run;
      if (ur_m) under_cnt++;
      if (fs_m) frame_cnt++;
    end
  end

  // ---------------- bit strobe generator ----------------
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk); #1;
      case (mode)
        0:       bit_en = 1'b1;
        1:       bit_en = (ph % 3 == 0);
        default: bit_en = ($urandom_range(0, 3) != 0);
      endcase
      ph++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [W-1:0] d);
    bus_m.in_valid = v; bus_m.in_data = d;
    bus_l.in_valid = v; bus_l.in_data = d;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Present a word and wait (bounded) for the edge that takes it.
  task automatic send(input logic [W-1:0] w, input bit keep);
    int n = 0;
    drive(1'b1, w);
    while (!(!m_hold_full && !rst) && n < 500) begin
      @(negedge clk); #1; n++;
    end
    check("send_accept_bound", n < 500, 1);
    @(negedge clk); #1;
    if (!keep) drive(1'b0, '0);
  endtask

  task automatic clear_caps();
    cap_m.delete(); cap_l.delete();
    under_cnt = 0; frame_cnt = 0; valid_cycles = 0; max_run = 0;
  endtask

  function automatic logic [W-1:0] pack(input int step, input bit lsb_q);
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) begin
      v = {v[W-2:0], (lsb_q ? cap_l[i*step] : cap_m[i*step])};
    end
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    drive(1'b0, '0);
    mode = 0;
    cycles(3);
    check("reset_in_ready", bus_m.in_ready, 0);
    check("reset_serial_valid", sv_m, 0);
    check("reset_serial_out", so_m, IDLE_BIT);
    rst = 0;

    // 1: single word, MSB first
    clear_caps();
    send(10'h2C5, 0);
    cycles(15);
    check("t1_bit_count", cap_m.size(), 10);
    if (cap_m.size() >= 10) check("t1_msb_bits", pack(1, 0), 10'h2C5);
    if (cap_l.size() >= 10) check("t1_lsb_bits", pack(1, 1), 10'h28D);
    check("t1_frame_starts", frame_cnt, 1);
    check("t1_underruns", under_cnt, 1);
    check("t1_valid_run", max_run, 10);
    check("t1_idle_level", so_m, IDLE_BIT);

    // 2: back-to-back words with in_valid held high
    clear_caps();
    send(10'h3FF, 1);
    send(10'h001, 0);
    cycles(25);
    check("t2_valid_run", max_run, 20);
    check("t2_frame_starts", frame_cnt, 2);
    check("t2_underruns", under_cnt, 1);

    // 3: LSB-first word 001 arrives as 1 then nine 0s
    clear_caps();
    send(10'h001, 0);
    cycles(15);
    if (cap_l.size() >= 10) check("t3_lsb_bits", pack(1, 1), 10'h200);
    if (cap_m.size() >= 10) check("t3_msb_bits", pack(1, 0), 10'h001);

    // 4: one strobe every third clock
    mode = 1;
    cycles(3);
    clear_caps();
    send(10'h155, 0);
    cycles(45);
    check("t4_valid_cycles", cap_m.size(), 30);
    if (cap_m.size() >= 30) begin
      int bad = 0;
      for (int i = 0; i < 30; i++) if (cap_m[i] !== cap_m[i - i % 3]) bad++;
      check("t4_bits_held_3", bad, 0);
      check("t4_pattern", pack(3, 0), 10'h155);
    end
    check("t4_underruns", under_cnt, 1);

    // 5: reset at bit 4 of word 1 with word 2 buffered
    mode = 0;
    cycles(2);
    send(10'h2AA, 1);
    send(10'h0F0, 0);
    begin
      int n = 0;
      while (!(m_active && m_bi == 4) && n < 100) begin cycles(1); n++; end
      check("t5_reach_bit4_bound", n < 100, 1);
    end
    check("t5_word2_buffered", bus_m.in_ready, 0);
    rst = 1;
    cycles(1);
    check("t5_rst_serial_out", so_m, IDLE_BIT);
    check("t5_rst_serial_valid", sv_m, 0);
    cycles(1);
    rst = 0;
    #1;
    check("t5_ready_after_release", bus_m.in_ready, 1);
    clear_caps();
    cycles(40);
    check("t5_word2_dropped", valid_cycles, 0);

    // 6: long idle
    clear_caps();
    cycles(50);
    check("t6_no_underrun", under_cnt, 0);
    check("t6_idle_level", so_m, IDLE_BIT);
    check("t6_in_ready", bus_m.in_ready, 1);

    // Randomized traffic: strobes, gaps, held valid and occasional reset
    mode = 2;
    for (int k = 0; k < 300; k++) begin
      cycles($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1; cycles(2); rst = 0;
      end
      send(W'($urandom_range(0, 1023)), bit'($urandom_range(0, 1)));
    end
    drive(1'b0, '0);
    mode = 0;
    cycles(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
